// File: rtl/prog_timer.sv
// Programmable tick/timeout counter: configurable width, runtime terminal value,
// up/down direction, periodic or one-shot mode, with a registered wrap pulse.
module prog_timer #(
  parameter int unsigned          WIDTH          = 7,
  parameter logic [WIDTH-1:0]     RESET_TERMINAL = '1
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             ce_i,
  input  logic             clear_i,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_value_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic             dir_i,
  input  logic             mode_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             running_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q,  wrap_d;
  logic             tc;

  // Up compare is >= so a load above max_i terminates on the next enabled cycle.
  assign tc = dir_i ? (count_q == '0) : (count_q >= max_i);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear_i) begin
      count_d = '0;
      state_d = S_IDLE;
    end else if (load_i) begin
      count_d = load_value_i;
    end else if (start_i) begin
      state_d = S_RUN;
      count_d = dir_i ? max_i : '0;
    end else if (state_q == S_RUN && ce_i) begin
      if (!tc) begin
        count_d = dir_i ? (count_q - 1'b1) : (count_q + 1'b1);
      end else begin
        wrap_d = 1'b1;
        if (mode_i) state_d = S_DONE;
        else        count_d = dir_i ? max_i : '0;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o   = count_q;
  assign tc_o      = tc;
  assign wrap_o    = wrap_q;
  assign running_o = (state_q == S_RUN);
  assign done_o    = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_timer.sv
// Self-checking bench for prog_timer: table-driven vectors fed through an
// expected-value queue, plus hand sequences for the legacy wrap and async reset.
module tb_prog_timer;
  localparam int unsigned W = 7;

  logic         clk = 1'b0, reset = 1'b1;
  logic         ce = 1'b0, clr = 1'b0, st = 1'b0, ld = 1'b0, dir = 1'b0, mode = 1'b0;
  logic [W-1:0] lv = '0, mx = 7'd127;
  logic [W-1:0] count;
  logic         tc, wrap, running, done;

  prog_timer #(.WIDTH(W), .RESET_TERMINAL(7'd127)) dut (
    .clk_i(clk), .reset_i(reset), .ce_i(ce), .clear_i(clr), .start_i(st),
    .load_i(ld), .load_value_i(lv), .max_i(mx), .dir_i(dir), .mode_i(mode),
    .count_o(count), .tc_o(tc), .wrap_o(wrap), .running_o(running), .done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         clr, ld, st, ce, dir, mode;
    logic [W-1:0] lv, mx, e_cnt;
    logic         e_tc, e_wrap, e_run, e_done;
  } vec_t;

  typedef struct {
    logic [W-1:0] cnt;
    logic         tc, wrap, run, done;
  } exp_t;

  vec_t        tab[$];
  exp_t        sb[$];
  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  function automatic vec_t v(input logic c, l, s, e, input logic [W-1:0] lval, mxv,
                             input logic d, m, input logic [W-1:0] cnt,
                             input logic etc, ewr, ern, edn);
    vec_t r;
    r.clr = c; r.ld = l; r.st = s; r.ce = e; r.lv = lval; r.mx = mxv;
    r.dir = d; r.mode = m; r.e_cnt = cnt;
    r.e_tc = etc; r.e_wrap = ewr; r.e_run = ern; r.e_done = edn;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
  endtask

  // Drive one vector, queue its expectation, then compare just after the edge.
  task automatic drive(input vec_t x);
    exp_t e;
    clr = x.clr; ld = x.ld; st = x.st; ce = x.ce; lv = x.lv; mx = x.mx;
    dir = x.dir; mode = x.mode;
    e.cnt = x.e_cnt; e.tc = x.e_tc; e.wrap = x.e_wrap; e.run = x.e_run; e.done = x.e_done;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 7'd1, 7'd0);
    end else begin
      e = sb.pop_front();
      chk("count",   count,   e.cnt);
      chk("tc",      tc,      e.tc);
      chk("wrap",    wrap,    e.wrap);
      chk("running", running, e.run);
      chk("done",    done,    e.done);
    end
  endtask

  initial begin
    // Test 3 table: one-shot down, ce on alternate cycles, max 5.
    tab.push_back(v(0,0,1,0, 0,5, 1,1, 5, 0,0,1,0));
    for (int k = 4; k >= 0; k--) begin
      tab.push_back(v(0,0,0,0, 0,5, 1,1, W'(k+1), 0,0,1,0));
      tab.push_back(v(0,0,0,1, 0,5, 1,1, W'(k), (k == 0),0,1,0));
    end
    tab.push_back(v(0,0,0,0, 0,5, 1,1, 0, 1,0,1,0));
    tab.push_back(v(0,0,0,1, 0,5, 1,1, 0, 1,1,0,1));
    tab.push_back(v(0,0,0,1, 0,5, 1,1, 0, 1,0,0,1));
    tab.push_back(v(0,0,0,1, 0,5, 1,1, 0, 1,0,0,1));
    tab.push_back(v(0,0,1,0, 0,5, 1,1, 5, 0,0,1,0));
    // Test 4 table: priority collision, then load beats start.
    tab.push_back(v(0,0,1,0, 0,20, 0,0, 0, 0,0,1,0));
    tab.push_back(v(0,0,0,1, 0,20, 0,0, 1, 0,0,1,0));
    tab.push_back(v(0,0,0,1, 0,20, 0,0, 2, 0,0,1,0));
    tab.push_back(v(0,0,0,1, 0,20, 0,0, 3, 0,0,1,0));
    tab.push_back(v(1,1,1,1, 9,20, 0,0, 0, 0,0,0,0));
    tab.push_back(v(0,1,1,0, 9,20, 0,0, 9, 0,0,0,0));
    tab.push_back(v(0,0,0,1, 9,20, 0,0, 9, 0,0,0,0));
    // Test 5 table: load beyond terminal in periodic up mode.
    tab.push_back(v(0,0,1,0, 0,10, 0,0, 0, 0,0,1,0));
    tab.push_back(v(0,1,0,0, 50,10, 0,0, 50, 1,0,1,0));
    tab.push_back(v(0,0,0,1, 50,10, 0,0, 0, 0,1,1,0));
    tab.push_back(v(0,0,0,0, 50,10, 0,0, 0, 0,0,1,0));
    // max 0, up, periodic: every ce is terminal, wrap on consecutive cycles.
    tab.push_back(v(0,0,1,0, 0,0, 0,0, 0, 1,0,1,0));
    tab.push_back(v(0,0,0,1, 0,0, 0,0, 0, 1,1,1,0));
    tab.push_back(v(0,0,0,1, 0,0, 0,0, 0, 1,1,1,0));

    // Reset state, checked while reset is held.
    #2;
    chk("reset_count",   count,   7'd0);
    chk("reset_wrap",    wrap,    7'd0);
    chk("reset_running", running, 7'd0);
    chk("reset_done",    done,    7'd0);
    @(negedge clk);
    reset = 1'b0;

    // Test 1: ce without start never counts.
    for (int i = 0; i < 10; i++) drive(v(0,0,0,1, 0,127, 0,0, 0, 0,0,0,0));

    // Test 2: legacy 0..127 periodic up.
    drive(v(0,0,1,0, 0,127, 0,0, 0, 0,0,1,0));
    for (int i = 1; i <= 127; i++)
      drive(v(0,0,0,1, 0,127, 0,0, W'(i), (i == 127),0,1,0));
    drive(v(0,0,0,1, 0,127, 0,0, 0, 0,1,1,0));
    drive(v(0,0,0,0, 0,127, 0,0, 0, 0,0,1,0));

    for (int i = 0; i < tab.size(); i++) drive(tab[i]);

    // Test 6: async reset between edges, then ce alone stays idle.
    drive(v(0,0,1,0, 0,127, 0,0, 0, 0,0,1,0));
    for (int i = 1; i <= 40; i++) drive(v(0,0,0,1, 0,127, 0,0, W'(i), 0,0,1,0));
    #3;
    reset = 1'b1;
    #1;
    chk("async_reset_count",   count,   7'd0);
    chk("async_reset_running", running, 7'd0);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) drive(v(0,0,0,1, 0,127, 0,0, 0, 0,0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/prog_timer.md
Name: prog_timer

Overview:
- Parametrised successor to the fixed 7-bit free-running counter.
- Adds configurable width, a runtime terminal value, up/down direction, periodic or one-shot mode, explicit start/clear/load controls and a registered wrap pulse.
- Sits beside datapath blocks as a general tick/timeout generator, driven by a clock-enable strobe.

Parameters:
- WIDTH, 7, counter and terminal-value width in bits (WIDTH ≥ 2).
- RESET_TERMINAL, 2**WIDTH-1, documentation default for max_i; tie max_i to it for legacy 0..127 behaviour.

Ports:
- clk_i  input  1  sole clock, rising edge.
- reset_i  input  1  asynchronous active-high reset.
- ce_i  input  1  count enable; acts only in RUN.
- clear_i  input  1  synchronous clear, highest priority.
- start_i  input  1  start or restart a count sequence.
- load_i  input  1  synchronous load of load_value_i.
- load_value_i  input  WIDTH  value written by load_i.
- max_i  input  WIDTH  terminal value; sampled live every cycle.
- dir_i  input  1  0 = count up 0..max_i; 1 = count down max_i..0.
- mode_i  input  1  0 = periodic (auto-restart); 1 = one-shot (stop at terminal).
- count_o  output  WIDTH  current count (register).
- tc_o  output  1  combinational terminal flag.
- wrap_o  output  1  registered 1-cycle pulse after each terminal event.
- running_o  output  1  state == RUN.
- done_o  output  1  state == DONE.

Behaviour:
- Interface: one clock clk_i; reset_i is asynchronous, active-high. Asserting reset_i forces count_o = 0, state = IDLE and wrap_o = 0 immediately. Release is synchronous to clk_i.
- States: IDLE, RUN, DONE. Only the state register and count_o hold state. wrap_o is a registered flag.
- tc_o definition:
  - dir_i = 0: tc_o = (count_o >= max_i).
  - dir_i = 1: tc_o = (count_o == 0).
- Per-edge priority, highest first:
  1. clear_i: count_o ← 0, state ← IDLE, wrap_o ← 0.
  2. load_i: count_o ← load_value_i. State is unchanged. wrap_o ← 0.
  3. start_i: state ← RUN; count_o ← 0 if dir_i = 0, else max_i. wrap_o ← 0. Valid from any state, so it restarts mid-run.
  4. state == RUN and ce_i = 1 and tc_o = 0: count_o ← count_o + 1 (up) or count_o − 1 (down). wrap_o ← 0.
  5. state == RUN and ce_i = 1 and tc_o = 1 (terminal event): wrap_o ← 1.
     - Periodic: count_o ← 0 (up) or max_i (down); state stays RUN.
     - One-shot: count_o holds; state ← DONE.
  6. Otherwise: count_o holds, wrap_o ← 0.
- Latency: wrap_o rises on the edge that processes the terminal event and is high for exactly one cycle. Back-to-back terminal events give wrap_o high on consecutive cycles.
- IDLE and DONE ignore ce_i. DONE is left only via start_i, clear_i or reset_i.
- Arithmetic is unsigned, modulo 2**WIDTH. With the terminal check above, neither direction can overflow past max_i in RUN.
- Load above max_i (up): the next ce is a terminal event (>= compare), so count_o → 0 or holds per mode. Load above max_i (down): count decrements normally to 0.
- max_i = 0:
  - Up: every ce in RUN is a terminal event.
  - Down: count_o is reloaded to 0, so every ce is terminal.
- max_i or dir_i changed mid-run: takes effect on the next evaluation; no glitch beyond the combinational tc_o.
- mode_i changed mid-run: only matters at the next terminal event.
- ce_i = 0 in RUN: everything holds; wrap_o deasserts after one cycle.
- Reset mid-operation: returns to IDLE and count_o = 0 regardless of other inputs.

Test Plan:
1. Reset and idle: WIDTH=7, pulse reset_i, then ce_i = 1 for 10 cycles without start_i → count_o = 0, running_o = 0, done_o = 0, wrap_o = 0 throughout.
2. Legacy compatibility: max_i = 127, dir_i = 0, mode_i = 0, start_i, then 128 ce → count_o runs 0..127 with tc_o = 1 at 127. On the 128th ce, count_o = 0 and wrap_o is high for one cycle.
3. One-shot down with gaps: max_i = 5, dir_i = 1, mode_i = 1, start_i (count_o = 5), ce on alternate cycles → count_o 5,5,4,4…0 holding on ce = 0 cycles. Next ce → done_o = 1, wrap_o pulse, count_o stays 0. Further ce gives no change. A subsequent start_i returns to RUN with count_o = 5.
4. Priority collision: in RUN at count_o = 3, assert clear_i + load_i + start_i + ce_i in one cycle → count_o = 0, IDLE. Then load_i + start_i with load_value_i = 9 → count_o = 9, state unchanged (IDLE).
5. Load beyond terminal: max_i = 10, up, periodic, RUN, load 50, then one ce → count_o = 0, wrap_o pulses once, running_o stays 1.
6. Async reset mid-run: count_o = 40 in RUN; assert reset_i between clock edges → count_o = 0 and running_o = 0 before the next edge. After release, ce alone does not count.
